// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: mode encodings, default sizing
// and a constant clog2 helper usable in parameter expressions.
package fifo_pkg;

    localparam int FIFO_STD   = 0;
    localparam int FIFO_FWFT  = 1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Smallest r such that 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port storage array: synchronous write, asynchronous (combinational) read.
// Contents are never reset; the surrounding FIFO only reads valid entries.
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming word when the FIFO accepts a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO. Pointers carry one extra wrap bit so
// full/empty fall out of a pointer compare; occupancy and all flags are
// registered alongside the pointers. Read port is either a registered
// output (standard) or a combinational head-of-queue view (FWFT).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    // Reject configurations the pointer/flag logic cannot represent.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH=%0d out of range 1..%0d", AF_THRESH, DEPTH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH=%0d out of range 0..%0d", AE_THRESH, DEPTH - 1);
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $error("sync_fifo_param: FWFT=%0d is not a valid read mode", FWFT);
    end

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_ptr_nxt;
    logic [AW:0]       rd_ptr_nxt;
    logic [AW:0]       count_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Accept decisions use the registered flags, so a full FIFO still
    // frees a slot on a read but drops a same-cycle write.
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        wr_ptr_nxt = wr_acc ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + PTR_ONE;
            2'b01:   count_nxt = count - PTR_ONE;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy, status flags and error pulses.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                            (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty        <= (wr_ptr_nxt == rd_ptr_nxt);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is visible as soon as the entry exists; zero while empty.
        assign data_out = empty ? '0 : ram_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        // Capture the head word on each accepted read; hold otherwise.
        always_ff @(posedge clk or posedge rst_a) begin
            if (rst_a) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= ram_rdata;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share the
// same stimulus and are both compared against a queue-based reference.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_a;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;
    int         wr_accepted;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst_a(rst_a), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst_a(rst_a), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [7:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : 8'h00;
        chk({tag, ".s.count"}, 32'(s_count), 32'(n));
        chk({tag, ".s.full"},  32'(s_full),  32'(n == 16));
        chk({tag, ".s.empty"}, 32'(s_empty), 32'(n == 0));
        chk({tag, ".s.af"},    32'(s_af),    32'(n >= 14));
        chk({tag, ".s.ae"},    32'(s_ae),    32'(n <= 2));
        chk({tag, ".s.ovf"},   32'(s_ovf),   32'(exp_ovf));
        chk({tag, ".s.unf"},   32'(s_unf),   32'(exp_unf));
        chk({tag, ".s.dout"},  32'(s_dout),  32'(exp_dout));
        chk({tag, ".f.count"}, 32'(f_count), 32'(n));
        chk({tag, ".f.full"},  32'(f_full),  32'(n == 16));
        chk({tag, ".f.empty"}, 32'(f_empty), 32'(n == 0));
        chk({tag, ".f.af"},    32'(f_af),    32'(n >= 14));
        chk({tag, ".f.ae"},    32'(f_ae),    32'(n <= 2));
        chk({tag, ".f.ovf"},   32'(f_ovf),   32'(exp_ovf));
        chk({tag, ".f.unf"},   32'(f_unf),   32'(exp_unf));
        chk({tag, ".f.dout"},  32'(f_dout),  32'(head));
    endtask

    // One clock cycle: drive, advance the model on the edge, check 1 ns later.
    task automatic cyc(input string tag, input logic w, input logic [7:0] d, input logic r);
        int  n;
        logic wacc, racc;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        n    = q.size();
        wacc = w && (n < 16);
        racc = r && (n > 0);
        exp_ovf = w && (n == 16);
        exp_unf = r && (n == 0);
        if (racc) exp_dout = q.pop_front();
        if (wacc) begin
            q.push_back(d);
            wr_accepted++;
        end
        #1;
        check_all(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Assert reset between edges and check outputs with no clock edge.
    task automatic async_reset(input string tag);
        #2 rst_a = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 rst_a = 1'b0;
        #1;
    endtask

    initial begin
        rst_a       = 1'b1;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        data_in     = 8'h00;
        wr_accepted = 0;
        model_reset();
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        #2 rst_a = 1'b0;
        #1;

        // Reset while idle and with data queued
        async_reset("rst_idle");
        for (int i = 0; i < 9; i++) cyc("pre9", 1'b1, 8'(8'h30 + i), 1'b0);
        chk("count9", 32'(s_count), 32'd9);
        async_reset("rst_at9");

        // Fill through the almost_empty / almost_full / full boundaries
        for (int i = 1; i <= 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0);
        chk("fill.full", 32'(s_full), 32'd1);
        cyc("ovf", 1'b1, 8'hFF, 1'b0);
        chk("ovf.pulse", 32'(s_ovf), 32'd1);
        chk("ovf.count", 32'(s_count), 32'd16);
        cyc("ovf_clr", 1'b0, 8'h00, 1'b0);

        // Drain in order, then underflow with held data
        for (int i = 1; i <= 16; i++) begin
            cyc("drain", 1'b0, 8'h00, 1'b1);
            chk("drain.data", 32'(s_dout), 32'(i));
        end
        cyc("unf", 1'b0, 8'h00, 1'b1);
        chk("unf.hold", 32'(s_dout), 32'h10);
        cyc("unf_clr", 1'b0, 8'h00, 1'b0);

        // Simultaneous read/write at mid, full and empty
        for (int i = 0; i < 5; i++) cyc("mid", 1'b1, 8'(8'h40 + i), 1'b0);
        cyc("mid_rw", 1'b1, 8'h55, 1'b1);
        chk("mid_rw.count", 32'(s_count), 32'd5);
        for (int i = 0; i < 11; i++) cyc("tofull", 1'b1, 8'(8'h60 + i), 1'b0);
        cyc("full_rw", 1'b1, 8'h77, 1'b1);
        chk("full_rw.ovf", 32'(s_ovf), 32'd1);
        for (int i = 0; i < 15; i++) cyc("drain2", 1'b0, 8'h00, 1'b1);
        cyc("empty_rw", 1'b1, 8'h99, 1'b1);
        chk("empty_rw.count", 32'(s_count), 32'd1);
        chk("empty_rw.unf", 32'(s_unf), 32'd1);
        cyc("empty_rw_pop", 1'b0, 8'h00, 1'b1);
        chk("empty_rw.data", 32'(s_dout), 32'h99);

        // FWFT head visibility and pop
        async_reset("rst_fwft");
        cyc("fwft_wr", 1'b1, 8'hA5, 1'b0);
        chk("fwft.head", 32'(f_dout), 32'hA5);
        chk("fwft.notempty", 32'(f_empty), 32'd0);
        cyc("fwft_rd", 1'b0, 8'h00, 1'b1);
        chk("fwft.empty", 32'(f_empty), 32'd1);
        chk("fwft.zero", 32'(f_dout), 32'h00);

        // Random traffic with wrap-around
        wr_accepted = 0;
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 99) < 80), 8'($urandom), ($urandom_range(0, 99) < 75));
        end
        chk("rand.wraps", 32'(wr_accepted >= 160), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
